quotient_converter: RTL
=======================

Name: quotient_converter

Overview:
- Receiving end of the divider's per-step digit selection (SignSel, Non0): accumulates the radix-2 signed-digit quotient stream {-1, 0, +1} into a two's-complement binary quotient.
- Uses on-the-fly conversion (Q / QM register pair), so no carry-propagate adder is in the per-step path.
- After the last digit, applies the remainder-correction decision (none / down / up) and presents the final quotient with a one-cycle valid pulse.

Parameters:
- parallelism, 32, operand width; quotient register is parallelism+1 bits ([parallelism:0]), matching the datapath width.
- cntBits, $clog2(parallelism+1), width of the step counter.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  begin a new conversion; honoured only in IDLE.
- digit_valid  input  1  SignSel/Non0 carry a quotient digit this cycle.
- SignSel  input  1  digit sign: 1 means -1 when Non0=1.
- Non0  input  1  0 means digit 0 (SignSel ignored).
- corr_valid  input  1  correction code valid; honoured only in WAIT_CORR.
- corr  input  2  00 none, 01 down (Q-1), 10 up (Q+1), 11 treated as none.
- busy  output  1  high in CONVERT and WAIT_CORR.
- quotient  output  parallelism+1  final quotient; held until the next start.
- quotient_valid  output  1  single-cycle pulse when quotient is updated.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; Q=0; QM=all ones; cnt=0; quotient=0; busy=0; quotient_valid=0.
- Digit decode:
  - Non0=0 gives d=0.
  - Non0=1, SignSel=0 gives d=+1.
  - Non0=1, SignSel=1 gives d=-1.
- On-the-fly update, one digit per accepted cycle, both registers shifted left by 1 with LSB appended:
  - d=+1: Q<={Q,1}, QM<={Q,0}
  - d=0: Q<={Q,0}, QM<={QM,1}
  - d=-1: Q<={QM,1}, QM<={QM,0}
  - Invariant: QM==Q-1 (mod 2^(parallelism+1)) at all times.
- IDLE:
  - start=1 → Q=0, QM=all ones, cnt=parallelism, go to CONVERT.
  - digit_valid and corr_valid are ignored.
- CONVERT:
  - digit_valid=1 → apply the update and decrement cnt.
  - When a digit is accepted with cnt==1 → go to WAIT_CORR.
  - digit_valid=0 → hold all state (stalls allowed, no timeout).
  - start and corr_valid are ignored.
- WAIT_CORR:
  - corr_valid=1 → register the result and go to IDLE; quotient_valid=1 for exactly that following cycle.
    - corr none/11: quotient<=Q.
    - corr down: quotient<=QM.
    - corr up: quotient<=Q+1, wrapping mod 2^(parallelism+1).
  - digit_valid and start are ignored.
- Latency: the result appears 1 cycle after corr_valid. Minimum start-to-valid time is parallelism+2 cycles.
- Back-to-back operation: start is accepted in the cycle quotient_valid is high, since the state is already IDLE.
- Reset mid-operation: everything is aborted immediately, and no quotient_valid is produced.
- The quotient output is held stable between valid pulses; a new start does not clear it.

Decomposition:
- Shared package (mdu_pkg):
  - state enum {IDLE, CONVERT, WAIT_CORR}
  - correction code constants CORR_NONE=2'b00, CORR_DOWN=2'b01, CORR_UP=2'b10
  - digit encoding constants matching the divider's SignSel/Non0 outputs.
- Optional sub-module otf_step: combinational next-Q/next-QM from (Q, QM, SignSel, Non0). It is reused by the FSM-controlled register stage.

Test Plan (parallelism=4, 5-bit quotient):
- Reset then start; digits +1,0,-1,+1 (SignSel/Non0 = 0/1, x/0, 1/1, 0/1); corr none → quotient=5'b00111 (7), single valid pulse, busy low afterwards.
- Same digit stream with corr down → quotient=6 (5'b00110); with corr up → quotient=8 (5'b01000).
- Four digits of -1, corr none → quotient=5'b10001 (-15); invariant QM==Q-1 checked every cycle.
- Digit stream with digit_valid gaps of 0–3 cycles, plus spurious start/corr_valid during CONVERT → result identical to the no-gap run (7); extra start ignored.
- rst_n asserted after 2 digits → all outputs 0 asynchronously. Then start plus four 0 digits and corr up → quotient=1, with no stale valid pulse.
- start asserted in the same cycle as quotient_valid → new conversion begins; extra digit_valid pulses in WAIT_CORR do not alter Q.

Source files
------------

// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared types and codes for the divider quotient path
// Purpose: FSM state type, remainder-correction codes and the {SignSel, Non0}
//          digit encodings produced by the divider's digit-selection logic.
// Ports:   none (package).
package mdu_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'b00,
      CONVERT   = 2'b01,
      WAIT_CORR = 2'b10
   } state_t;

   localparam logic [1:0] CORR_NONE = 2'b00;
   localparam logic [1:0] CORR_DOWN = 2'b01;
   localparam logic [1:0] CORR_UP   = 2'b10;

   // Digit encodings as {SignSel, Non0}. SignSel is a don't-care for zero.
   localparam logic [1:0] DIGIT_ZERO = 2'b00;
   localparam logic [1:0] DIGIT_POS  = 2'b01;
   localparam logic [1:0] DIGIT_NEG  = 2'b11;

endpackage

// File: rtl/quotient_converter_if.sv
// rtl/quotient_converter_if.sv - digit/correction/result bundle of the quotient converter
// Purpose: groups the control, digit, correction and result signals that pass
//          between the divider (master) and the quotient converter (slave).
// Ports:   start, digit_valid, SignSel, Non0, corr_valid, corr  (master -> slave)
//          busy, quotient, quotient_valid                       (slave -> master)
interface quotient_converter_if #(
   parameter int parallelism = 32
);

   logic                   start;
   logic                   digit_valid;
   logic                   SignSel;
   logic                   Non0;
   logic                   corr_valid;
   logic [1:0]             corr;
   logic                   busy;
   logic [parallelism:0]   quotient;
   logic                   quotient_valid;

   modport master (
      output start, digit_valid, SignSel, Non0, corr_valid, corr,
      input  busy, quotient, quotient_valid
   );

   modport slave (
      input  start, digit_valid, SignSel, Non0, corr_valid, corr,
      output busy, quotient, quotient_valid
   );

endinterface

// File: rtl/otf_step.sv
// rtl/otf_step.sv - combinational on-the-fly conversion step
// Purpose: next Q / QM from the current pair and one radix-2 signed digit.
//          Keeps QM == Q-1 without any carry-propagate addition.
// Ports:   q, qm (in, width)      current register pair
//          sign_sel, non0 (in)    digit as {SignSel, Non0}
//          q_next, qm_next (out)  shifted pair with the digit appended
module otf_step
   import mdu_pkg::*;
#(
   parameter int width = 33
) (
   input  logic [width-1:0] q,
   input  logic [width-1:0] qm,
   input  logic             sign_sel,
   input  logic             non0,
   output logic [width-1:0] q_next,
   output logic [width-1:0] qm_next
);

   always_comb begin
      // Zero digit (any SignSel when non0 is low) is the default.
      q_next  = {q[width-2:0], 1'b0};
      qm_next = {qm[width-2:0], 1'b1};
      case ({sign_sel, non0})
         DIGIT_POS: begin
            q_next  = {q[width-2:0], 1'b1};
            qm_next = {q[width-2:0], 1'b0};
         end
         DIGIT_NEG: begin
            // A -1 digit borrows from the upper part, which QM already holds.
            q_next  = {qm[width-2:0], 1'b1};
            qm_next = {qm[width-2:0], 1'b0};
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/quotient_converter.sv
// rtl/quotient_converter.sv - on-the-fly signed-digit to binary quotient converter
// Purpose: accepts one radix-2 quotient digit {-1,0,+1} per digit_valid cycle,
//          builds the two's-complement quotient in a Q/QM register pair, then
//          applies the remainder correction (none/down/up) and presents the
//          result with a one-cycle quotient_valid pulse.
// Ports:   clk (in)     rising-edge clock
//          rst_n (in)   asynchronous active-low reset
//          bus (slave)  start/digit/correction inputs, busy/quotient/valid outputs
module quotient_converter
   import mdu_pkg::*;
#(
   parameter int parallelism = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   quotient_converter_if.slave  bus
);

   localparam int cntBits = $clog2(parallelism + 1);
   localparam int qw      = parallelism + 1;

   state_t               state;
   logic [qw-1:0]        q;
   logic [qw-1:0]        qm;
   logic [qw-1:0]        q_next;
   logic [qw-1:0]        qm_next;
   logic [cntBits-1:0]   cnt;
   logic [qw-1:0]        quotient_r;
   logic                 quotient_valid_r;
   logic                 busy_r;

   otf_step #(
      .width (qw)
   ) u_otf_step (
      .q        (q),
      .qm       (qm),
      .sign_sel (bus.SignSel),
      .non0     (bus.Non0),
      .q_next   (q_next),
      .qm_next  (qm_next)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state            <= IDLE;
         q                <= '0;
         qm               <= '1;
         cnt              <= '0;
         quotient_r       <= '0;
         quotient_valid_r <= 1'b0;
         busy_r           <= 1'b0;
      end else begin
         quotient_valid_r <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  q      <= '0;
                  qm     <= '1;
                  cnt    <= cntBits'(parallelism);
                  state  <= CONVERT;
                  busy_r <= 1'b1;
               end
            end
            CONVERT: begin
               if (bus.digit_valid) begin
                  q   <= q_next;
                  qm  <= qm_next;
                  cnt <= cnt - cntBits'(1);
                  if (cnt == cntBits'(1)) begin
                     state <= WAIT_CORR;
                  end
               end
            end
            WAIT_CORR: begin
               if (bus.corr_valid) begin
                  case (bus.corr)
                     CORR_DOWN: quotient_r <= qm;
                     CORR_UP:   quotient_r <= q + qw'(1);
                     default:   quotient_r <= q;
                  endcase
                  quotient_valid_r <= 1'b1;
                  state            <= IDLE;
                  busy_r           <= 1'b0;
               end
            end
            default: begin
               state  <= IDLE;
               busy_r <= 1'b0;
            end
         endcase
      end
   end

   assign bus.busy           = busy_r;
   assign bus.quotient       = quotient_r;
   assign bus.quotient_valid = quotient_valid_r;

endmodule
